pc_unit: RTL

- Parametrised program-counter unit; successor to the plain PC register in the fetch stage.
- Holds the fetch address, advances it sequentially, and applies stall, branch/jump, trap and call/return redirects in a fixed priority.
- Contains a DEPTH-entry return-address stack (RAS) that predicts return targets.
- Flags misaligned redirect targets and RAS misses to the control unit.

---
 rtl/pc_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects (trap, stall, return,
// branch/jump, sequential) and a circular return-address stack.
module pc_unit #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                INC          = 4,
    parameter int                ALIGN_BITS   = 2,
    parameter int                DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         br_taken,
    input  logic                         jump,
    input  logic [WIDTH-1:0]             br_target,
    input  logic                         is_call,
    input  logic                         is_ret,
    input  logic                         trap_valid,
    input  logic [WIDTH-1:0]             trap_vector,
    output logic [WIDTH-1:0]             pc_out,
    output logic                         pc_valid,
    output logic [$clog2(DEPTH+1)-1:0]   ras_count,
    output logic                         ras_miss,
    output logic                         misalign_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    top_q, top_d;
    logic             miss_q, miss_d;
    logic             misalign_q, misalign_d;
    logic [WIDTH-1:0] ras_mem_q [DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] sel_target;
    logic [PW-1:0]    top_next, top_prev;
    logic             ras_empty, ras_full;
    logic             ras_we;
    logic [PW-1:0]    ras_waddr;

    assign pc_inc    = pc_q + WIDTH'(INC);
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CW'(DEPTH));
    assign top_next  = (top_q == PW'(DEPTH - 1)) ? '0 : top_q + PW'(1);
    assign top_prev  = (top_q == '0) ? PW'(DEPTH - 1) : top_q - PW'(1);

    // Pushing onto a full stack advances top over the oldest entry, which
    // is exactly the overwrite-oldest behaviour of the circular buffer.
    always_comb begin
        pc_d       = pc_q;
        valid_d    = 1'b1;
        count_d    = count_q;
        top_d      = top_q;
        miss_d     = 1'b0;
        misalign_d = 1'b0;
        ras_we     = 1'b0;
        ras_waddr  = top_next;
        sel_target = br_target;

        if (trap_valid) begin
            pc_d = trap_vector;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (is_ret) begin
            sel_target = ras_empty ? br_target : ras_mem_q[top_q];
            miss_d     = ras_empty;
            if ((sel_target & ALIGN_MASK) != '0) begin
                misalign_d = 1'b1;
            end else begin
                pc_d = sel_target;
                if (jump && is_call) begin
                    ras_we = 1'b1;
                    if (ras_empty) begin
                        ras_waddr = top_next;
                        top_d     = top_next;
                        count_d   = CW'(1);
                    end else begin
                        ras_waddr = top_q;
                    end
                end else if (!ras_empty) begin
                    top_d   = top_prev;
                    count_d = count_q - CW'(1);
                end
            end
        end else if (jump || br_taken) begin
            if ((br_target & ALIGN_MASK) != '0) begin
                misalign_d = 1'b1;
            end else begin
                pc_d = br_target;
                if (jump && is_call) begin
                    ras_we    = 1'b1;
                    ras_waddr = top_next;
                    top_d     = top_next;
                    if (!ras_full) begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            count_q    <= '0;
            top_q      <= '0;
            miss_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            top_q      <= top_d;
            miss_q     <= miss_d;
            misalign_q <= misalign_d;
        end
    end

    // Stack storage needs no reset: entries are only read while counted live.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem_q[ras_waddr] <= pc_inc;
        end
    end

    assign pc_out       = pc_q;
    assign pc_valid     = valid_q;
    assign ras_count    = count_q;
    assign ras_miss     = miss_q;
    assign misalign_err = misalign_q;

endmodule
